// File: rtl/expr_judge.sv
// expr_judge: judges the player's keypad answer against a captured expression.
// Build option: define JUDGE_TIMEOUT_EN to add an answer-window down-counter
// (TIMEOUT_CYCLES ENTRY cycles); without it ENTRY waits indefinitely and
// timeout_o is tied low.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start_i         capture request (honoured in IDLE only)
//   exp_i, line_i   expression word {num1, op, num2} and its lane
//   key_valid_i     one keypad event this cycle
//   key_code_i      0-9 digit, C clear, E sign toggle, F enter
//   busy_o          high in EVAL, ENTRY and JUDGE
//   q_exp_o         captured expression
//   q_line_o        captured lane
//   answer_o        signed result of q_exp_o
//   entry_o         signed value entered so far
//   correct_o       one-cycle pulse on a right answer
//   wrong_o         one-cycle pulse on a wrong answer
//   timeout_o       one-cycle pulse when the answer window expired
//   score_o         saturating count of correct answers
module expr_judge #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [11:0] exp_i,
    input  logic [1:0]  line_i,
    input  logic        key_valid_i,
    input  logic [3:0]  key_code_i,
    output logic        busy_o,
    output logic [11:0] q_exp_o,
    output logic [1:0]  q_line_o,
    output logic [7:0]  answer_o,
    output logic [7:0]  entry_o,
    output logic        correct_o,
    output logic        wrong_o,
    output logic        timeout_o,
    output logic [7:0]  score_o
);

    localparam int unsigned EXP_W = 12;
    localparam int unsigned VAL_W = 8;
    localparam int unsigned MAG_W = 7;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_ENTRY = 2'd2,
        S_JUDGE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [EXP_W-1:0]   q_exp_q, q_exp_d;
    logic [1:0]         q_line_q, q_line_d;
    logic [VAL_W-1:0]   answer_q, answer_d;
    logic [VAL_W-1:0]   entry_q, entry_d;
    logic [VAL_W-1:0]   score_q, score_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic               sign_q, sign_d;
    logic [1:0]         ndig_q, ndig_d;
    logic               busy_q, busy_d;
    logic               correct_q, correct_d;
    logic               wrong_q, wrong_d;

    logic               enter_c;
    logic               expire_c;
    logic               timed_out_c;
    logic [VAL_W-1:0]   eval_c;
    logic [3:0]         a_c, b_c;

    assign enter_c = key_valid_i && (key_code_i == 4'hF);
    assign a_c     = q_exp_q[11:8];
    assign b_c     = q_exp_q[3:0];

    // Expression evaluator; subtraction wraps naturally into two's complement.
    always_comb begin
        eval_c = '0;
        case (q_exp_q[7:4])
            4'hA:    eval_c = VAL_W'(a_c) + VAL_W'(b_c);
            4'hB:    eval_c = VAL_W'(a_c) - VAL_W'(b_c);
            4'hC:    eval_c = VAL_W'(a_c) * VAL_W'(b_c);
            4'hD:    eval_c = (b_c == 4'd0) ? '0 : VAL_W'(a_c / b_c);
            default: eval_c = '0;
        endcase
    end

`ifdef JUDGE_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timed_out_q, timed_out_d;
    logic             timeout_q, timeout_d;

    // Expiry fires on the ENTRY edge that takes the counter to zero.
    assign expire_c    = (tmo_cnt_q <= CNT_W'(1));
    assign timed_out_c = timed_out_q;
    assign timeout_o   = timeout_q;

    // Answer-window counter and the forced-wrong flag carried into JUDGE.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        timed_out_d = 1'b0;
        timeout_d   = 1'b0;
        if (state_q == S_EVAL) begin
            tmo_cnt_d = CNT_W'(TIMEOUT_CYCLES);
        end else if (state_q == S_ENTRY) begin
            if (tmo_cnt_q != '0) begin
                tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
            end
            timed_out_d = expire_c && !enter_c;
        end else if (state_q == S_JUDGE) begin
            timeout_d = timed_out_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q   <= '0;
            timed_out_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            timed_out_q <= timed_out_d;
            timeout_q   <= timeout_d;
        end
    end
`else
    logic unused_tmo_c;

    assign unused_tmo_c = |TIMEOUT_CYCLES;
    assign expire_c     = 1'b0;
    assign timed_out_c  = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        q_exp_d   = q_exp_q;
        q_line_d  = q_line_q;
        answer_d  = answer_q;
        score_d   = score_q;
        mag_d     = mag_q;
        sign_d    = sign_q;
        ndig_d    = ndig_q;
        correct_d = 1'b0;
        wrong_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_EVAL;
                    q_exp_d  = exp_i;
                    q_line_d = line_i;
                    mag_d    = '0;
                    sign_d   = 1'b0;
                    ndig_d   = '0;
                end
            end
            S_EVAL: begin
                answer_d = eval_c;
                state_d  = S_ENTRY;
            end
            S_ENTRY: begin
                if (key_valid_i) begin
                    if (key_code_i <= 4'd9) begin
                        // Third and later digits are dropped.
                        if (ndig_q < 2'd2) begin
                            mag_d  = mag_q * MAG_W'(10) + MAG_W'(key_code_i);
                            ndig_d = ndig_q + 2'd1;
                        end
                    end else if (key_code_i == 4'hE) begin
                        sign_d = ~sign_q;
                    end else if (key_code_i == 4'hC) begin
                        mag_d  = '0;
                        sign_d = 1'b0;
                        ndig_d = '0;
                    end
                end
                // Enter wins over a simultaneous expiry.
                if (enter_c || expire_c) begin
                    state_d = S_JUDGE;
                end
            end
            S_JUDGE: begin
                state_d = S_IDLE;
                if (!timed_out_c && (entry_q == answer_q)) begin
                    correct_d = 1'b1;
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                end else begin
                    wrong_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        // Negative zero folds to 0 because 0 - 0 is 0.
        entry_d = sign_d ? (8'd0 - {1'b0, mag_d}) : {1'b0, mag_d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            q_exp_q   <= '0;
            q_line_q  <= '0;
            answer_q  <= '0;
            entry_q   <= '0;
            score_q   <= '0;
            mag_q     <= '0;
            sign_q    <= 1'b0;
            ndig_q    <= '0;
            busy_q    <= 1'b0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_exp_q   <= q_exp_d;
            q_line_q  <= q_line_d;
            answer_q  <= answer_d;
            entry_q   <= entry_d;
            score_q   <= score_d;
            mag_q     <= mag_d;
            sign_q    <= sign_d;
            ndig_q    <= ndig_d;
            busy_q    <= busy_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
        end
    end

    assign busy_o    = busy_q;
    assign q_exp_o   = q_exp_q;
    assign q_line_o  = q_line_q;
    assign answer_o  = answer_q;
    assign entry_o   = entry_q;
    assign correct_o = correct_q;
    assign wrong_o   = wrong_q;
    assign score_o   = score_q;

endmodule

// File: tb/tb_expr_judge.sv
// Self-checking bench for expr_judge: directed vector table, randomized
// questions against a digit-list reference model, and corner sequences.
module tb_expr_judge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [11:0] exp_i = '0;
    logic [1:0]  line_i = '0;
    logic        key_valid_i = 1'b0;
    logic [3:0]  key_code_i = '0;
    logic        busy_o;
    logic [11:0] q_exp_o;
    logic [1:0]  q_line_o;
    logic [7:0]  answer_o;
    logic [7:0]  entry_o;
    logic        correct_o;
    logic        wrong_o;
    logic        timeout_o;
    logic [7:0]  score_o;

    int checks = 0;
    int errors = 0;
    int score_m = 0;

    expr_judge #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .exp_i(exp_i), .line_i(line_i),
        .key_valid_i(key_valid_i), .key_code_i(key_code_i), .busy_o(busy_o),
        .q_exp_o(q_exp_o), .q_line_o(q_line_o), .answer_o(answer_o), .entry_o(entry_o),
        .correct_o(correct_o), .wrong_o(wrong_o), .timeout_o(timeout_o), .score_o(score_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [11:0] e;
        logic [1:0]  ln;
        logic [3:0]  nk;
        logic [23:0] keys;   // key i in keys[4*i +: 4]
        logic [7:0]  ans;
        logic [7:0]  ent;
        logic        corr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_answer(input logic [11:0] e);
        int a = int'(e[11:8]);
        int b = int'(e[3:0]);
        int r;
        case (e[7:4])
            4'hA:    r = a + b;
            4'hB:    r = a - b;
            4'hC:    r = a * b;
            4'hD:    r = (b == 0) ? 0 : a / b;
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    function automatic logic [7:0] model_entry(input int nk, input logic [23:0] ks);
        int digits[$];
        bit neg = 0;
        int v = 0;
        logic [3:0] k;
        for (int i = 0; i < nk; i++) begin
            k = ks[4*i +: 4];
            if (k <= 4'd9) begin
                if (digits.size() < 2) digits.push_back(int'(k));
            end else if (k == 4'hE) begin
                neg = !neg;
            end else if (k == 4'hC) begin
                digits.delete();
                neg = 0;
            end
        end
        foreach (digits[i]) v = v * 10 + digits[i];
        if (neg) v = -v;
        return 8'(v);
    endfunction

    task automatic send_keys(input int nk, input logic [23:0] ks);
        for (int i = 0; i < nk; i++) begin
            key_valid_i = 1'b1;
            key_code_i  = ks[4*i +: 4];
            tick();
        end
        key_valid_i = 1'b0;
    endtask

    task automatic pulse_check(input string tag, input logic want_corr);
        tick();
        if (want_corr && score_m < 255) score_m++;
        chk({tag, "_correct"}, 32'(correct_o), 32'(want_corr));
        chk({tag, "_wrong"}, 32'(wrong_o), 32'(!want_corr));
        chk({tag, "_timeout"}, 32'(timeout_o), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy_o), 32'd0);
        chk({tag, "_score"}, 32'(score_o), 32'(score_m));
        tick();
        chk({tag, "_pulse_len"}, 32'({correct_o, wrong_o}), 32'd0);
    endtask

    // Full question from IDLE: capture, evaluate, key entry, judge.
    task automatic question(input logic [11:0] e, input logic [1:0] ln, input int nk,
                            input logic [23:0] ks, input logic [7:0] want_ans,
                            input logic [7:0] want_ent, input logic want_corr, input string tag);
        exp_i = e;
        line_i = ln;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        chk({tag, "_q_exp"}, 32'(q_exp_o), 32'(e));
        chk({tag, "_q_line"}, 32'(q_line_o), 32'(ln));
        tick();
        chk({tag, "_answer"}, 32'(answer_o), 32'(want_ans));
        send_keys(nk, ks);
        chk({tag, "_entry"}, 32'(entry_o), 32'(want_ent));
        pulse_check(tag, want_corr);
    endtask

    task automatic push_key(inout int nk, inout logic [23:0] ks, input logic [3:0] k);
        ks[4*nk +: 4] = k;
        nk++;
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{12'h3A4, 2'd2, 4'd2, 24'h0000F7, 8'h07, 8'h07, 1'b1};
        tbl[1] = '{12'h2B9, 2'd1, 4'd3, 24'h000F7E, 8'hF9, 8'hF9, 1'b1};
        tbl[2] = '{12'h2B9, 2'd0, 4'd2, 24'h0000F7, 8'hF9, 8'h07, 1'b0};
        tbl[3] = '{12'h9C9, 2'd3, 4'd4, 24'h00F518, 8'h51, 8'h51, 1'b1};
        tbl[4] = '{12'h7D2, 2'd1, 4'd4, 24'h00F4C3, 8'h03, 8'h04, 1'b0};
        tbl[5] = '{12'h5D0, 2'd2, 4'd1, 24'h00000F, 8'h00, 8'h00, 1'b1};
        tbl[6] = '{12'h4B4, 2'd0, 4'd3, 24'h000F0E, 8'h00, 8'h00, 1'b1};
        tbl[7] = '{12'h5E3, 2'd3, 4'd2, 24'h0000F0, 8'h00, 8'h00, 1'b1};
        tbl[8] = '{12'h3A4, 2'd1, 4'd5, 24'h0FDB7A, 8'h07, 8'h07, 1'b1};
        tbl[9] = '{12'hFCF, 2'd2, 4'd4, 24'h00F13E, 8'hE1, 8'hE1, 1'b1};

        // Reset values
        tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_q_exp", 32'(q_exp_o), 32'd0);
        chk("rst_q_line", 32'(q_line_o), 32'd0);
        chk("rst_answer", 32'(answer_o), 32'd0);
        chk("rst_entry", 32'(entry_o), 32'd0);
        chk("rst_correct", 32'(correct_o), 32'd0);
        chk("rst_wrong", 32'(wrong_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_score", 32'(score_o), 32'd0);
        rst = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 10; i++) begin
            question(tbl[i].e, tbl[i].ln, int'(tbl[i].nk), tbl[i].keys,
                     tbl[i].ans, tbl[i].ent, tbl[i].corr, $sformatf("vec%0d", i));
        end

        // Randomized questions against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [11:0] e;
            logic [23:0] ks;
            logic [7:0]  ans;
            logic [7:0]  ent;
            logic [3:0]  k;
            int nk;
            int rs;
            int mag;
            int op;
            e = 12'($urandom);
            op = int'($urandom_range(0, 7));
            e[7:4] = (op < 4) ? 4'(10 + op) : 4'($urandom);
            ans = ref_answer(e);
            rs = int'($signed(ans));
            ks = '0;
            nk = 0;
            if ($urandom_range(0, 1) == 1 && rs >= -99 && rs <= 99) begin
                mag = (rs < 0) ? -rs : rs;
                if (rs < 0) push_key(nk, ks, 4'hE);
                if (mag >= 10) push_key(nk, ks, 4'(mag / 10));
                push_key(nk, ks, 4'(mag % 10));
            end else begin
                for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
                    k = 4'($urandom);
                    if (k == 4'hF) k = 4'h9;
                    push_key(nk, ks, k);
                end
            end
            push_key(nk, ks, 4'hF);
            ent = model_entry(nk, ks);
            question(e, 2'($urandom), nk, ks, ans, ent, ent == ans, $sformatf("rnd%0d", n));
        end

        // start during ENTRY is ignored
        exp_i = 12'h3A4;
        line_i = 2'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        exp_i = 12'hFFF;
        line_i = 2'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("ign_start_q_exp", 32'(q_exp_o), 32'h3A4);
        chk("ign_start_q_line", 32'(q_line_o), 32'd1);
        chk("ign_start_busy", 32'(busy_o), 32'd1);
        send_keys(2, 24'h0000F7);
        chk("ign_start_entry", 32'(entry_o), 32'h07);
        pulse_check("ign_start", 1'b1);

`ifdef JUDGE_TIMEOUT_EN
        // Expiry forces wrong even with the right value entered
        exp_i = 12'h3A4;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        for (int i = 1; i <= 8; i++) begin
            key_valid_i = (i == 1);
            key_code_i = 4'h7;
            tick();
            chk($sformatf("tmo_wait%0d", i), 32'({busy_o, wrong_o, timeout_o}), 32'b100);
        end
        key_valid_i = 1'b0;
        tick();
        chk("tmo_wrong", 32'(wrong_o), 32'd1);
        chk("tmo_timeout", 32'(timeout_o), 32'd1);
        chk("tmo_correct", 32'(correct_o), 32'd0);
        chk("tmo_score", 32'(score_o), 32'(score_m));
        tick();
        chk("tmo_pulse_len", 32'({wrong_o, timeout_o}), 32'd0);

        // Enter on the expiry edge is judged normally
        exp_i = 12'h3A4;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        for (int i = 1; i <= 8; i++) begin
            key_valid_i = (i == 1) || (i == 8);
            key_code_i = (i == 1) ? 4'h7 : 4'hF;
            tick();
        end
        key_valid_i = 1'b0;
        pulse_check("tmo_prio", 1'b1);
`else
        // Without the timeout the answer window never closes
        exp_i = 12'h3A4;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        for (int i = 0; i < 100; i++) begin
            tick();
            chk($sformatf("notmo_busy%0d", i), 32'({busy_o, wrong_o, timeout_o}), 32'b100);
        end
        send_keys(2, 24'h0000F7);
        pulse_check("notmo_end", 1'b1);
`endif

        // Score saturation
        for (int i = 0; i < 256; i++) begin
            question(12'h5D0, 2'd0, 1, 24'h00000F, 8'h00, 8'h00, 1'b1, "sat");
        end
        chk("sat_score", 32'(score_o), 32'd255);

        // Asynchronous reset mid-entry
        exp_i = 12'h9C9;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        send_keys(1, 24'h000008);
        chk("mid_entry", 32'(entry_o), 32'h08);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_q_exp", 32'(q_exp_o), 32'd0);
        chk("mid_rst_q_line", 32'(q_line_o), 32'd0);
        chk("mid_rst_answer", 32'(answer_o), 32'd0);
        chk("mid_rst_entry", 32'(entry_o), 32'd0);
        chk("mid_rst_pulses", 32'({correct_o, wrong_o, timeout_o}), 32'd0);
        chk("mid_rst_score", 32'(score_o), 32'd0);
        score_m = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_pulses", 32'({correct_o, wrong_o, busy_o}), 32'd0);
        question(12'h2B9, 2'd2, 3, 24'h000F7E, 8'hF9, 8'hF9, 1'b1, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
